// File: rtl/timer_pkg.sv
// Shared types and constants for the keypad-loaded MM:SS countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } timer_state_e;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

    // Wide enough for any DONE_TICKS in 1..15.
    localparam int unsigned DONE_CNT_W = 4;

endpackage

// File: rtl/keypad_timer_loader_bcd_down_digit.sv
// One BCD digit of the countdown: clear, parallel load, or decrement with wrap to WRAP.
// borrow_out tells the next more-significant digit to decrement.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] WRAP = BCD_MAX
) (
    input  logic               clock,
    input  logic               clearn,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               dec_in,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out
);

    // Digit register: clear beats load beats decrement.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec_in) begin
            q <= (q == '0) ? WRAP : q - DIGIT_W'(1);
        end
    end

    assign borrow_out = dec_in && (q == '0);

endmodule

// File: rtl/keypad_timer_loader.sv
// Keypad-loaded MM:SS countdown timer with IDLE/RUN/PAUSE/DONE control.
// Optional build macro SEC_NORMALIZE_EN: on IDLE->RUN, seconds >= 60 are folded into minutes
// (saturating at 99:59); without it the entered value runs raw.
module keypad_timer_loader
    import timer_pkg::*;
#(
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic               clock,
    input  logic               clearn,
    input  logic [DIGIT_W-1:0] d_in,
    input  logic               loadn,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               tick,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               zero,
    output logic               running,
    output logic               done
);

    localparam logic [DONE_CNT_W-1:0] DONE_LAST = DONE_CNT_W'(DONE_TICKS - 1);

    timer_state_e              state_q, state_d;
    logic                      loadn_q;
    logic [DONE_CNT_W-1:0]     cnt_q, cnt_d;

    logic                      capture;
    logic                      at_last;
    logic                      clr_all;
    logic                      ld_all;
    logic [3:0][DIGIT_W-1:0]   ld_val;   // [0]=sec_ones .. [3]=min_tens
    logic                      tick_dec;
    logic                      b_so, b_st, b_mo;
    logic                      unused_borrow;

    // State, loadn edge register and DONE tick counter.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            state_q <= StIdle;
            loadn_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            loadn_q <= loadn;
            cnt_q   <= cnt_d;
        end
    end

    assign capture = loadn_q && !loadn && (d_in <= BCD_MAX);
    // The only value that a single decrement takes to 00:00.
    assign at_last = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0)
                     && (sec_ones == DIGIT_W'(1));

    // Next state and digit commands; the highest-priority event that applies wins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_all  = 1'b0;
        ld_all   = 1'b0;
        ld_val   = '0;
        tick_dec = 1'b0;
        if (clear) begin
            state_d = StIdle;
            cnt_d   = '0;
            clr_all = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !zero) begin
                        state_d = StRun;
`ifdef SEC_NORMALIZE_EN
                        if (sec_tens > SEC_TENS_MAX) begin
                            ld_all = 1'b1;
                            if (min_tens == BCD_MAX && min_ones == BCD_MAX) begin
                                ld_val = {BCD_MAX, BCD_MAX, SEC_TENS_MAX, BCD_MAX};
                            end else if (min_ones == BCD_MAX) begin
                                ld_val = {min_tens + 4'd1, 4'd0, sec_tens - 4'd6, sec_ones};
                            end else begin
                                ld_val = {min_tens, min_ones + 4'd1, sec_tens - 4'd6, sec_ones};
                            end
                        end
`endif
                    end else if (capture) begin
                        ld_all = 1'b1;
                        ld_val = {min_ones, sec_tens, sec_ones, d_in};
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StPause;
                    end else if (tick) begin
                        tick_dec = 1'b1;
                        if (at_last) begin
                            state_d = StDone;
                            cnt_d   = '0;
                        end
                    end
                end
                StPause: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    if (tick) begin
                        if (cnt_q == DONE_LAST) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + DONE_CNT_W'(1);
                        end
                    end else if (capture) begin
                        // Fresh entry: the new digit lands on a cleared display.
                        state_d = StIdle;
                        cnt_d   = '0;
                        ld_all  = 1'b1;
                        ld_val  = {4'd0, 4'd0, 4'd0, d_in};
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    bcd_down_digit #(.WRAP(BCD_MAX)) u_sec_ones (
        .clock      (clock),
        .clearn     (clearn),
        .clr        (clr_all),
        .load       (ld_all),
        .load_val   (ld_val[0]),
        .dec_in     (tick_dec),
        .q          (sec_ones),
        .borrow_out (b_so)
    );

    bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
        .clock      (clock),
        .clearn     (clearn),
        .clr        (clr_all),
        .load       (ld_all),
        .load_val   (ld_val[1]),
        .dec_in     (b_so),
        .q          (sec_tens),
        .borrow_out (b_st)
    );

    bcd_down_digit #(.WRAP(BCD_MAX)) u_min_ones (
        .clock      (clock),
        .clearn     (clearn),
        .clr        (clr_all),
        .load       (ld_all),
        .load_val   (ld_val[2]),
        .dec_in     (b_st),
        .q          (min_ones),
        .borrow_out (b_mo)
    );

    bcd_down_digit #(.WRAP(BCD_MAX)) u_min_tens (
        .clock      (clock),
        .clearn     (clearn),
        .clr        (clr_all),
        .load       (ld_all),
        .load_val   (ld_val[3]),
        .dec_in     (b_mo),
        .q          (min_tens),
        .borrow_out (unused_borrow)
    );

    assign zero    = (sec_ones == '0) && (sec_tens == '0) && (min_ones == '0) && (min_tens == '0);
    assign running = (state_q == StRun);
    assign done    = (state_q == StDone);

endmodule

// File: tb/tb_keypad_timer_loader.sv
// Bench for keypad_timer_loader: directed keypad/control stimulus, an integer MM:SS model
// compared on every cycle, plus hand-computed checkpoints.
module tb_keypad_timer_loader;

    localparam int unsigned DT = 3;

    logic       clock = 1'b0;
    logic       clearn, loadn, start, stop, clear, tick;
    logic [3:0] d_in;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       zero, running, done;

    keypad_timer_loader #(.DONE_TICKS(DT)) dut (
        .clock    (clock),
        .clearn   (clearn),
        .d_in     (d_in),
        .loadn    (loadn),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .tick     (tick),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .zero     (zero),
        .running  (running),
        .done     (done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [18:0] dut_vec;
    assign dut_vec = {min_tens, min_ones, sec_tens, sec_ones, zero, running, done};

    function automatic logic [18:0] mk(input int mt, input int mo, input int st, input int so,
                                       input int z, input int r, input int d);
        return {4'(mt), 4'(mo), 4'(st), 4'(so), 1'(z), 1'(r), 1'(d)};
    endfunction

    // Model: minutes and seconds as plain integers; 0=idle 1=run 2=pause 3=done.
    int m_mm = 0, m_ss = 0, m_st = 0, m_cnt = 0;
    bit m_prev = 1'b1;

    always @(posedge clock) begin
        bit cap;
        int n;
        cap = m_prev && !loadn && (d_in <= 4'd9);
        m_prev = loadn;
        if (!clearn) begin
            m_mm = 0; m_ss = 0; m_st = 0; m_cnt = 0; m_prev = 1'b1;
        end else if (clear) begin
            m_mm = 0; m_ss = 0; m_st = 0; m_cnt = 0;
        end else begin
            case (m_st)
                0: begin
                    if (start && (m_mm + m_ss != 0)) begin
                        m_st = 1;
`ifdef SEC_NORMALIZE_EN
                        if (m_ss >= 60) begin
                            if (m_mm == 99) m_ss = 59;
                            else begin m_ss -= 60; m_mm += 1; end
                        end
`endif
                    end else if (cap) begin
                        n = ((m_mm * 100 + m_ss) * 10 + int'(d_in)) % 10000;
                        m_mm = n / 100;
                        m_ss = n % 100;
                    end
                end
                1: begin
                    if (stop) m_st = 2;
                    else if (tick) begin
                        if (m_ss > 0) m_ss -= 1;
                        else begin m_ss = 59; m_mm -= 1; end
                        if (m_mm == 0 && m_ss == 0) begin m_st = 3; m_cnt = 0; end
                    end
                end
                2: if (start) m_st = 1;
                default: begin
                    if (tick) begin
                        m_cnt += 1;
                        if (m_cnt == DT) begin m_st = 0; m_cnt = 0; end
                    end else if (cap) begin
                        m_mm = 0; m_ss = int'(d_in); m_st = 0; m_cnt = 0;
                    end
                end
            endcase
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clock) begin
        logic [18:0] exp;
        if (chk_en) begin
            exp = mk(m_mm / 10, m_mm % 10, m_ss / 10, m_ss % 10,
                     (m_mm == 0 && m_ss == 0) ? 1 : 0, (m_st == 1) ? 1 : 0, (m_st == 3) ? 1 : 0);
            n_cmp++;
            if (dut_vec !== exp) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t got=%h want=%h", $time, dut_vec, exp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input int len);
        d_in = d; loadn = 1'b0; cyc(len);
        loadn = 1'b1; cyc(2);
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cyc(1); clear = 1'b0;
    endtask

    task automatic lit(input string name, input logic [18:0] exp);
        @(negedge clock);
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", name, dut_vec, exp);
        end
    endtask

    initial begin
        clearn = 1'b0; loadn = 1'b1; start = 1'b0; stop = 1'b0;
        clear = 1'b0; tick = 1'b0; d_in = 4'd0;
        cyc(2);
        clearn = 1'b1;
        chk_en = 1'b1;
        lit("reset", mk(0, 0, 0, 0, 1, 0, 0));

        // Capture and count.
        press(4'd1, 5); press(4'd3, 5); press(4'd0, 5);
        lit("load_0130", mk(0, 1, 3, 0, 0, 0, 0));
        pulse_start();
        lit("start_run", mk(0, 1, 3, 0, 0, 1, 0));
        do_tick(1);
        lit("tick_0129", mk(0, 1, 2, 9, 0, 1, 0));
        press(4'd4, 3);
        lit("key_in_run", mk(0, 1, 2, 9, 0, 1, 0));
        do_tick(30);
        lit("tick_0059", mk(0, 0, 5, 9, 0, 1, 0));

        // Held key and illegal digit.
        pulse_clear();
        press(4'd7, 20);
        lit("held_key", mk(0, 0, 0, 7, 0, 0, 0));
        press(4'd12, 1);
        lit("illegal_digit", mk(0, 0, 0, 7, 0, 0, 0));

        // Pause and priority.
        pulse_clear();
        press(4'd1, 2); press(4'd0, 2);
        pulse_start();
        stop = 1'b1; tick = 1'b1; cyc(1); stop = 1'b0; tick = 1'b0;
        lit("stop_tick", mk(0, 0, 1, 0, 0, 0, 0));
        do_tick(2);
        pulse_start();
        do_tick(1);
        lit("resume_tick", mk(0, 0, 0, 9, 0, 1, 0));
        clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
        lit("clear_start", mk(0, 0, 0, 0, 1, 0, 0));

        // Expiry.
        press(4'd2, 5);
        pulse_start();
        do_tick(2);
        lit("expire", mk(0, 0, 0, 0, 1, 0, 1));
        do_tick(DT - 1);
        lit("done_hold", mk(0, 0, 0, 0, 1, 0, 1));
        do_tick(1);
        lit("done_exit", mk(0, 0, 0, 0, 1, 0, 0));
        pulse_start();
        lit("start_zero", mk(0, 0, 0, 0, 1, 0, 0));

        // Reentry from DONE.
        press(4'd3, 2);
        pulse_start();
        do_tick(3);
        lit("done_again", mk(0, 0, 0, 0, 1, 0, 1));
        d_in = 4'd5; loadn = 1'b0; cyc(1);
        lit("reentry", mk(0, 0, 0, 5, 0, 0, 0));
        loadn = 1'b1; cyc(2);

        // Seconds above 59.
        pulse_clear();
        press(4'd0, 5); press(4'd9, 5); press(4'd0, 5);
        lit("raw_0090", mk(0, 0, 9, 0, 0, 0, 0));
        pulse_start();
`ifdef SEC_NORMALIZE_EN
        lit("norm_start", mk(0, 1, 3, 0, 0, 1, 0));
        do_tick(1);
        lit("norm_tick", mk(0, 1, 2, 9, 0, 1, 0));
`else
        lit("raw_start", mk(0, 0, 9, 0, 0, 1, 0));
        do_tick(1);
        lit("raw_tick", mk(0, 0, 8, 9, 0, 1, 0));
`endif
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
